// File: rtl/i2c_burst_controller_if.sv
// Control-side bundle for i2c_burst_controller: start request, latched transaction fields,
// per-byte write/read handshakes and status.
interface i2c_burst_controller_if #(
    parameter int MAX_BYTES = 4
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);

    logic            enable;
    logic            mode;
    logic [6:0]      periph_addr;
    logic [NB_W-1:0] num_bytes;
    logic [7:0]      transmit_byte;
    logic            tx_next;
    logic [7:0]      read_byte;
    logic            rx_valid;
    logic            ready;
    logic            nack;
    logic [3:0]      state;

    modport master (
        input  enable, mode, periph_addr, num_bytes, transmit_byte,
        output tx_next, read_byte, rx_valid, ready, nack, state
    );

    modport slave (
        output enable, mode, periph_addr, num_bytes, transmit_byte,
        input  tx_next, read_byte, rx_valid, ready, nack, state
    );
endinterface

// File: rtl/i2c_burst_controller.sv
// I2C master running multi-byte burst reads/writes to one 7-bit peripheral per transaction.
// Each bit is four quarters of CLK_DIV clocks; SCL/SDA levels are registered from next-state values.
module i2c_burst_controller #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_burst_controller_if.master ctl,
    output logic                  scl,
    inout  wire                   sda
);
    localparam int NB_W  = $clog2(MAX_BYTES + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(MAX_BYTES);
    localparam logic [NB_W-1:0]  NB_ONE   = NB_W'(1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WR_BYTE  = 4'd4,
        WR_ACK   = 4'd5,
        RD_BYTE  = 4'd6,
        RD_ACK   = 4'd7,
        STOP     = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       quarter_q, quarter_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             mode_q, mode_d;
    logic [6:0]       addr_q, addr_d;
    logic [NB_W-1:0]  total_q, total_d;
    logic [NB_W-1:0]  count_q, count_d;
    logic             sampled_q, sampled_d;
    logic             rx_pend_q, rx_pend_d;
    logic             nack_q, nack_d;
    logic             ready_q, ready_d;
    logic             tx_next_q, tx_next_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       read_byte_q, read_byte_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;

    logic sda_in_s;
    logic bit_end_s;
    logic sample_s;
    logic last_byte_s;

    function automatic logic scl_level(input state_t st, input logic [1:0] qt);
        case (st)
            IDLE:    scl_level = 1'b1;
            START:   scl_level = (qt != 2'd3);
            STOP:    scl_level = (qt != 2'd0);
            default: scl_level = (qt == 2'd1) || (qt == 2'd2);
        endcase
    endfunction

    // START pulls SDA in the second half of the bit, STOP in the first half.
    function automatic logic sda_pull_low(input state_t st, input logic [1:0] qt,
                                          input logic data_bit, input logic ack_out);
        case (st)
            START:         sda_pull_low = qt[1];
            STOP:          sda_pull_low = ~qt[1];
            ADDR, WR_BYTE: sda_pull_low = ~data_bit;
            RD_ACK:        sda_pull_low = ack_out;
            default:       sda_pull_low = 1'b0;
        endcase
    endfunction

    assign sda_in_s    = sda;
    assign bit_end_s   = (div_q == DIV_LAST) && (quarter_q == 2'd3);
    assign sample_s    = (div_q == {DIV_W{1'b0}}) && (quarter_q == 2'd2);
    assign last_byte_s = ((count_q + NB_ONE) >= total_q);

    // Next-state, bit timing, byte sequencing and bus levels.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        total_d     = total_q;
        count_d     = count_q;
        nack_d      = nack_q;
        read_byte_d = read_byte_q;
        sampled_d   = sampled_q;
        rx_pend_d   = 1'b0;
        tx_next_d   = 1'b0;
        rx_valid_d  = 1'b0;

        if (state_q == IDLE) begin
            div_d     = {DIV_W{1'b0}};
            quarter_d = 2'd0;
        end else if (div_q == DIV_LAST) begin
            div_d     = {DIV_W{1'b0}};
            quarter_d = quarter_q + 2'd1;
        end else begin
            div_d     = div_q + DIV_ONE;
        end

        if (rx_pend_q) begin
            read_byte_d = shift_q;
            rx_valid_d  = 1'b1;
        end else begin
            read_byte_d = read_byte_q;
        end

        if (sample_s) begin
            sampled_d = sda_in_s;
        end else begin
            sampled_d = sampled_q;
        end

        case (state_q)
            IDLE: begin
                if (ctl.enable && ready_q) begin
                    mode_d  = ctl.mode;
                    addr_d  = ctl.periph_addr;
                    total_d = (ctl.num_bytes > NB_MAX) ? NB_MAX : ctl.num_bytes;
                    count_d = {NB_W{1'b0}};
                    nack_d  = 1'b0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = ADDR;
                    shift_d = {addr_q, ~mode_q};
                    bit_d   = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            ADDR, WR_BYTE: begin
                if (bit_end_s && (bit_q == 3'd7)) begin
                    if (state_q == ADDR) begin
                        state_d = ADDR_ACK;
                    end else begin
                        state_d = WR_ACK;
                    end
                end else if (bit_end_s) begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end else begin
                    state_d = state_q;
                end
            end
            ADDR_ACK: begin
                if (bit_end_s) begin
                    bit_d = 3'd0;
                    if (sampled_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (total_q == {NB_W{1'b0}}) begin
                        state_d = STOP;
                    end else if (mode_q) begin
                        state_d   = WR_BYTE;
                        shift_d   = ctl.transmit_byte;
                        tx_next_d = 1'b1;
                    end else begin
                        state_d = RD_BYTE;
                    end
                end else begin
                    state_d = ADDR_ACK;
                end
            end
            WR_ACK: begin
                if (bit_end_s) begin
                    count_d = count_q + NB_ONE;
                    bit_d   = 3'd0;
                    if (sampled_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if (last_byte_s) begin
                        state_d = STOP;
                    end else begin
                        state_d   = WR_BYTE;
                        shift_d   = ctl.transmit_byte;
                        tx_next_d = 1'b1;
                    end
                end else begin
                    state_d = WR_ACK;
                end
            end
            RD_BYTE: begin
                if (sample_s) begin
                    shift_d   = {shift_q[6:0], sda_in_s};
                    rx_pend_d = (bit_q == 3'd7);
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s && (bit_q == 3'd7)) begin
                    state_d = RD_ACK;
                end else if (bit_end_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    state_d = RD_BYTE;
                end
            end
            RD_ACK: begin
                if (bit_end_s) begin
                    count_d = count_q + NB_ONE;
                    bit_d   = 3'd0;
                    if (last_byte_s) begin
                        state_d = STOP;
                    end else begin
                        state_d = RD_BYTE;
                    end
                end else begin
                    state_d = RD_ACK;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Levels follow the upcoming state so SCL/SDA line up with the state register.
        ready_d  = (state_d == IDLE);
        scl_d    = scl_level(state_d, quarter_d);
        sda_oe_d = sda_pull_low(state_d, quarter_d, shift_d[7], ~last_byte_s);
    end

    // State, timing and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= {DIV_W{1'b0}};
            quarter_q   <= 2'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            mode_q      <= 1'b0;
            addr_q      <= 7'h00;
            total_q     <= {NB_W{1'b0}};
            count_q     <= {NB_W{1'b0}};
            sampled_q   <= 1'b0;
            rx_pend_q   <= 1'b0;
            nack_q      <= 1'b0;
            ready_q     <= 1'b1;
            tx_next_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            read_byte_q <= 8'h00;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            count_q     <= count_d;
            sampled_q   <= sampled_d;
            rx_pend_q   <= rx_pend_d;
            nack_q      <= nack_d;
            ready_q     <= ready_d;
            tx_next_q   <= tx_next_d;
            rx_valid_q  <= rx_valid_d;
            read_byte_q <= read_byte_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign ctl.tx_next   = tx_next_q;
    assign ctl.read_byte = read_byte_q;
    assign ctl.rx_valid  = rx_valid_q;
    assign ctl.ready     = ready_q;
    assign ctl.nack      = nack_q;
    assign ctl.state     = state_q;
    assign scl           = scl_q;
    assign sda           = sda_oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_burst_controller.sv
// Bench for i2c_burst_controller: behavioural peripheral at 7'h05 on a pulled-up SDA, directed
// cases plus randomized bursts checked against transaction-level expectations.
module tb_i2c_burst_controller;
    localparam int         CLK_DIV   = 4;
    localparam int         MAX_BYTES = 4;
    localparam int         BIT_CLKS  = 4 * CLK_DIV;
    localparam logic [6:0] PERIPH    = 7'h05;

    logic clk;
    logic reset;
    logic scl;
    wire  sda;
    logic p_drive;

    i2c_burst_controller_if #(.MAX_BYTES(MAX_BYTES)) ctl_if ();

    i2c_burst_controller #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl_if),
        .scl   (scl),
        .sda   (sda)
    );

    pullup (sda);
    assign sda = p_drive ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [7:0] wr_data [8];
    logic [7:0] rd_data [8];
    logic [7:0] byte_log [$];
    bit         mack_log [$];
    int         stop_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Peripheral: counts SCL rises per byte; phase 0 idle, 1 address, 2 write data, 3 read data.
    int         p_phase;
    int         p_cnt;
    int         rd_idx;
    logic [7:0] p_acc;
    logic [7:0] p_tx;
    bit         p_ack;
    bit         p_rd;
    bit         p_mack;
    logic       prev_scl;
    logic       prev_sda;

    initial begin
        p_drive = 1'b0; p_phase = 0; p_cnt = 0; rd_idx = 0; p_acc = 8'h00; p_tx = 8'h00;
        p_ack = 1'b0; p_rd = 1'b0; p_mack = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_drive = 1'b0; p_phase = 0; p_cnt = 0;
            end else if (prev_scl && scl && prev_sda && !sda) begin
                p_phase = 1; p_cnt = 0; p_drive = 1'b0; rd_idx = 0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                p_phase = 0; p_drive = 1'b0; stop_count++;
            end else if (p_phase != 0 && !prev_scl && scl) begin
                p_cnt++;
                if (p_phase != 3 && p_cnt <= 8) p_acc = {p_acc[6:0], sda};
                if (p_phase == 3 && p_cnt == 9) begin
                    p_mack = !sda;
                    mack_log.push_back(p_mack);
                end
            end else if (p_phase != 0 && prev_scl && !scl) begin
                if (p_phase == 3) begin
                    if (p_cnt >= 1 && p_cnt <= 7) p_drive = !p_tx[7 - p_cnt];
                    else if (p_cnt == 8) p_drive = 1'b0;
                    else if (p_cnt == 9) begin
                        p_cnt = 0;
                        if (p_mack) begin
                            p_tx = rd_data[rd_idx]; rd_idx++; p_drive = !p_tx[7];
                        end else begin
                            p_phase = 0; p_drive = 1'b0;
                        end
                    end
                end else if (p_cnt == 8) begin
                    byte_log.push_back(p_acc);
                    if (p_phase == 1) p_rd = p_acc[0];
                    p_ack = (p_phase == 2) || (p_acc[7:1] == PERIPH);
                    p_drive = p_ack;
                end else if (p_cnt == 9) begin
                    p_drive = 1'b0; p_cnt = 0;
                    if (!p_ack) p_phase = 0;
                    else if (p_phase == 1 && p_rd) begin
                        p_phase = 3; p_tx = rd_data[rd_idx]; rd_idx++; p_drive = !p_tx[7];
                    end else p_phase = 2;
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // One transaction; abort_at > 0 pulses reset that many clocks after the start edge.
    task automatic run_txn(input logic [6:0] addr, input logic mode, input logic [2:0] nb,
                           input bit hold, input int abort_at);
        int         n;
        int         ntx;
        int         nexp;
        bit         acked;
        bit         done;
        logic [7:0] rx_q [$];
        nexp  = (nb > 3'd4) ? 4 : int'(nb);
        acked = (addr == PERIPH);
        if (!acked) nexp = 0;
        byte_log.delete(); mack_log.delete(); rx_q.delete();
        stop_count = 0; ntx = 0; n = 0; done = 1'b0;
        @(negedge clk);
        ctl_if.enable = 1'b1; ctl_if.mode = mode; ctl_if.periph_addr = addr;
        ctl_if.num_bytes = nb; ctl_if.transmit_byte = wr_data[0];
        @(posedge clk); #1;
        if (!hold) ctl_if.enable = 1'b0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                check_eq("ready_drop", 32'(ctl_if.ready), 32'd0);
                check_eq("nack_clear", 32'(ctl_if.nack), 32'd0);
            end
            if (ctl_if.tx_next) begin
                ntx++;
                ctl_if.transmit_byte = wr_data[ntx];
            end
            if (ctl_if.rx_valid) rx_q.push_back(ctl_if.read_byte);
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b1;
                #1;
                check_eq("rst_scl", 32'(scl), 32'd1);
                check_eq("rst_sda", 32'(sda), 32'd1);
                check_eq("rst_state", 32'(ctl_if.state), 32'd0);
                check_eq("rst_ready", 32'(ctl_if.ready), 32'd1);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (ctl_if.ready) done = 1'b1;
        end
        check_eq("timeout", 32'(done), 32'd1);
        check_eq("length", 32'(n), 32'((2 + 9 * (1 + nexp)) * BIT_CLKS));
        check_eq("nack", 32'(ctl_if.nack), 32'(!acked));
        check_eq("tx_pulses", 32'(ntx), mode ? 32'(nexp) : 32'd0);
        check_eq("rx_pulses", 32'(rx_q.size()), mode ? 32'd0 : 32'(nexp));
        check_eq("stops", 32'(stop_count), 32'd1);
        check_eq("bus_bytes", 32'(byte_log.size()), 32'(1 + (mode ? nexp : 0)));
        if (byte_log.size() > 0) check_eq("addr_byte", 32'(byte_log[0]), 32'({addr, ~mode}));
        if (!mode) check_eq("mack_count", 32'(mack_log.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (mode && (i + 1 < byte_log.size()))
                check_eq("wr_byte", 32'(byte_log[i + 1]), 32'(wr_data[i]));
            if (!mode && i < rx_q.size())
                check_eq("rd_byte", 32'(rx_q[i]), 32'(rd_data[i]));
            if (!mode && i < mack_log.size())
                check_eq("master_ack", 32'(mack_log[i]), 32'(i < nexp - 1));
        end
        if (hold) begin
            @(posedge clk); #1;
            check_eq("hold_restart", 32'(ctl_if.ready), 32'd0);
            ctl_if.enable = 1'b0;
            for (int k = 0; k < 2000 && !ctl_if.ready; k++) begin
                @(posedge clk); #1;
            end
            check_eq("hold_drain", 32'(ctl_if.ready), 32'd1);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; stop_count = 0;
        reset = 1'b1;
        ctl_if.enable = 1'b0; ctl_if.mode = 1'b0; ctl_if.periph_addr = 7'h00;
        ctl_if.num_bytes = 3'd0; ctl_if.transmit_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wr_data[i] = 8'h00;
            rd_data[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_scl", 32'(scl), 32'd1);
        check_eq("reset_sda", 32'(sda), 32'd1);
        check_eq("reset_ready", 32'(ctl_if.ready), 32'd1);
        check_eq("reset_nack", 32'(ctl_if.nack), 32'd0);
        check_eq("reset_state", 32'(ctl_if.state), 32'd0);
        check_eq("reset_pulses", 32'({ctl_if.tx_next, ctl_if.rx_valid}), 32'd0);
        check_eq("reset_rdbyte", 32'(ctl_if.read_byte), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        wr_data[0] = 8'h07;
        run_txn(7'h05, 1'b1, 3'd1, 1'b0, 0);

        wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_data[2] = 8'h33;
        run_txn(7'h05, 1'b1, 3'd3, 1'b0, 0);

        rd_data[0] = 8'hA5; rd_data[1] = 8'h3C;
        run_txn(7'h05, 1'b0, 3'd2, 1'b0, 0);

        run_txn(7'h06, 1'b1, 3'd2, 1'b0, 0);

        wr_data[0] = 8'h9C; wr_data[1] = 8'h6B;
        run_txn(7'h05, 1'b1, 3'd2, 1'b0, 370);
        wr_data[0] = 8'h5A;
        run_txn(7'h05, 1'b1, 3'd1, 1'b0, 0);

        run_txn(7'h05, 1'b1, 3'd0, 1'b1, 0);

        repeat (10) begin
            for (int i = 0; i < 8; i++) begin
                wr_data[i] = 8'($urandom_range(0, 255));
                rd_data[i] = 8'($urandom_range(0, 255));
            end
            run_txn(($urandom_range(0, 3) == 0) ? 7'h06 : 7'h05, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
